// File: rtl/feeder_pkg.sv
// Shared types and helpers for the serial pattern feeder.
package feeder_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } feeder_state_t;

    localparam int FEEDER_WIDTH_DEFAULT = 8;

    // Bit-index counter width; a 2-bit word still needs one counter bit.
    function automatic int cnt_bits(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/feeder_hold_reg.sv
// One-entry valid/ready holding buffer; the consumer empties it with take.
module feeder_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             take,
    output logic             in_ready,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    // Accept and take are mutually exclusive: accept needs the buffer empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (in_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

    assign in_ready = !hold_full;

endmodule

// File: rtl/serial_pattern_feeder.sv
// Parallel-to-serial feeder: double-buffered words shifted out one bit per clock,
// back-to-back words stream with no gap bits.
module serial_pattern_feeder
    import feeder_pkg::*;
#(
    parameter int   WIDTH     = FEEDER_WIDTH_DEFAULT,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    feeder_state_t    state, state_n;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             load;

    feeder_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .take      (load),
        .in_ready  (in_ready),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == LAST) begin
                    if (hold_full) load    = 1'b1;
                    else           state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Reload restarts the index; otherwise the word moves toward the output end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                sreg <= hold_data;
                cnt  <= '0;
            end else if (state == S_SHIFT) begin
                sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                cnt  <= cnt + CW'(1);
            end
        end
    end

    assign ser_valid = (state == S_SHIFT);
    assign ser_bit   = ser_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;
    assign ser_first = ser_valid && (cnt == '0);
    assign ser_last  = ser_valid && (cnt == LAST);
    assign busy      = ser_valid || hold_full;

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Scoreboard bench for serial_pattern_feeder: MSB-first, LSB-first and idle-high instances.
module tb_serial_pattern_feeder;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;

    logic in_ready, ser_bit, ser_valid, ser_first, ser_last, busy;
    logic l_in_ready, l_ser_bit, l_ser_valid, l_ser_first, l_ser_last, l_busy;
    logic i_in_ready, i_ser_bit, i_ser_valid, i_ser_first, i_ser_last, i_busy;

    exp_t q_msb[$];
    exp_t q_lsb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
    );

    serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_in_ready), .ser_bit(l_ser_bit), .ser_valid(l_ser_valid),
        .ser_first(l_ser_first), .ser_last(l_ser_last), .busy(l_busy)
    );

    serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_idle1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(i_in_ready), .ser_bit(i_ser_bit), .ser_valid(i_ser_valid),
        .ser_first(i_ser_first), .ser_last(i_ser_last), .busy(i_busy)
    );

    // Expected serial stream in both bit orders for one accepted word.
    function automatic void push_word(input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            q_msb.push_back('{b: w[7-k], first: (k == 0), last: (k == 7)});
            q_lsb.push_back('{b: w[k],   first: (k == 0), last: (k == 7)});
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            vectors++;
            if (ser_valid) begin
                if (q_msb.size() == 0) begin
                    miscompares++;
                    $display("FAIL msb_unexpected_bit: got bit=%b with nothing expected", ser_bit);
                end else begin
                    e = q_msb.pop_front();
                    if ({ser_bit, ser_first, ser_last} !== {e.b, e.first, e.last}) begin
                        miscompares++;
                        $display("FAIL msb_stream: got bit/first/last=%b%b%b expected %b%b%b",
                                 ser_bit, ser_first, ser_last, e.b, e.first, e.last);
                    end
                end
            end else if ({ser_bit, ser_first, ser_last} !== 3'b000) begin
                miscompares++;
                $display("FAIL msb_idle: got bit/first/last=%b%b%b expected 000",
                         ser_bit, ser_first, ser_last);
            end
            vectors++;
            if (l_ser_valid) begin
                if (q_lsb.size() == 0) begin
                    miscompares++;
                    $display("FAIL lsb_unexpected_bit: got bit=%b with nothing expected", l_ser_bit);
                end else begin
                    e = q_lsb.pop_front();
                    if ({l_ser_bit, l_ser_first, l_ser_last} !== {e.b, e.first, e.last}) begin
                        miscompares++;
                        $display("FAIL lsb_stream: got bit/first/last=%b%b%b expected %b%b%b",
                                 l_ser_bit, l_ser_first, l_ser_last, e.b, e.first, e.last);
                    end
                end
            end else if ({l_ser_bit, l_ser_first, l_ser_last} !== 3'b000) begin
                miscompares++;
                $display("FAIL lsb_idle: got bit/first/last=%b%b%b expected 000",
                         l_ser_bit, l_ser_first, l_ser_last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] w, output int waited);
        in_data  = w;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end
        push_word(w);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_msb.size() != 0 || q_lsb.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (q_msb.size() != 0 || q_lsb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d/%0d bits left, expected 0/0", q_msb.size(), q_lsb.size());
        end
        vectors++;
        if ({ser_valid, ser_bit, busy, in_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL drain_idle: valid/bit/busy/ready=%b%b%b%b expected 0001",
                     ser_valid, ser_bit, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, ser_valid, ser_bit, ser_first, ser_last, busy} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_outputs: ready/valid/bit/first/last/busy=%b%b%b%b%b%b expected 100000",
                     in_ready, ser_valid, ser_bit, ser_first, ser_last, busy);
        end
        vectors++;
        if ({i_ser_bit, i_ser_valid, i_busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_idle_high: bit/valid/busy=%b%b%b expected 100", i_ser_bit, i_ser_valid, i_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        int w;
        send(8'hCB, w);
        in_valid = 1'b0;
        vectors++;
        if ({ser_valid, busy, in_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL single_after_accept: valid/busy/ready=%b%b%b expected 010", ser_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if ({ser_valid, ser_first, ser_bit} !== 3'b111) begin
            miscompares++;
            $display("FAIL single_first_bit: valid/first/bit=%b%b%b expected 111", ser_valid, ser_first, ser_bit);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int run = 0;
        send(8'hCB, w);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_low: in_ready=%b expected 0", in_ready);
        end
        in_data = 8'h35;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready_after_load: in_ready=%b expected 1", in_ready);
                end
                push_word(8'h35);
            end
            if (c == 2) in_valid = 1'b0;
            if (c <= 16 && ser_valid === 1'b1) run++;
        end
        vectors++;
        if (run != 16) begin
            miscompares++;
            $display("FAIL b2b_contiguous: %0d valid cycles expected 16", run);
        end
        vectors++;
        if (ser_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: ser_valid=%b expected 0", ser_valid);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w0, w1, w2;
        send(8'h01, w0);
        send(8'h80, w1);
        send(8'hFF, w2);
        in_valid = 1'b0;
        vectors++;
        if (w1 != 1) begin
            miscompares++;
            $display("FAIL bp_second_wait: waited %0d cycles expected 1", w1);
        end
        vectors++;
        if (w2 != 7) begin
            miscompares++;
            $display("FAIL bp_third_wait: waited %0d cycles expected 7", w2);
        end
        drain();
    endtask

    task automatic test_reset_mid_word();
        int w;
        send(8'hCB, w);
        in_data = 8'h35;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({ser_valid, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL midrst_pre: valid/busy=%b%b expected 11", ser_valid, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        q_msb.delete();
        q_lsb.delete();
        #1;
        vectors++;
        if ({ser_valid, ser_bit, in_ready, busy, ser_first, ser_last} !== 6'b001000) begin
            miscompares++;
            $display("FAIL midrst_flush: valid/bit/ready/busy/first/last=%b%b%b%b%b%b expected 001000",
                     ser_valid, ser_bit, in_ready, busy, ser_first, ser_last);
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({ser_valid, l_ser_valid, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL midrst_no_resume: cycle %0d valid/lvalid/busy=%b%b%b expected 000",
                         c, ser_valid, l_ser_valid, busy);
            end
        end
    endtask

    task automatic test_idle_high();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({i_ser_bit, i_ser_valid, i_busy} !== 3'b100) begin
                miscompares++;
                $display("FAIL idle_high: cycle %0d bit/valid/busy=%b%b%b expected 100",
                         c, i_ser_bit, i_ser_valid, i_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_idle_high();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
